// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM state encoding
//   DEFAULT_RESET_PC : PC loaded on reset
//   DEFAULT_PC_STEP  : PC increment per sequential instruction
package fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int unsigned DEFAULT_RESET_PC = 0;
    localparam int unsigned DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/fetch_unit_ifid.sv
// ifid_reg: IF/ID pipeline register.
//   clk, rst_n       : clock, async active-low reset
//   clear            : drop contents to a bubble (highest priority)
//   hold             : keep current contents
//   load             : capture load_instr/load_pc as a valid entry
//   load_instr/pc    : word and its PC to capture
//   instr, pc, valid : register outputs to decode
// With none of clear/hold/load asserted the entry becomes a bubble.
module ifid_reg #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               hold,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            // instr/pc keep their old values; only valid matters downstream
            valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                instr <= load_instr;
                pc    <= load_pc;
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with IF/ID register.
// Owns the PC, keeps at most one request outstanding to instruction memory,
// obeys stall/flush from the hazard unit and redirects on taken branches.
//   clk, rst_n                    : clock, async active-low reset
//   stall, flush_ifid             : hazard-unit controls
//   branchTakenFlag, branchTarget : redirect from EX
//   imem_req, imem_addr           : memory request (combinational)
//   imem_rdata, imem_valid        : memory response
//   instr_IFID, pc_IFID, valid_IFID : IF/ID contents presented to decode
//
// state | meaning
// ISSUE | no request outstanding, issue one for pc
// WAIT  | request for pc outstanding, response wanted
// HOLD  | response for pc parked in hold buffer while stalled
// DRAIN | request outstanding but redirected; discard its response
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEFAULT_PC_STEP)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush_ifid,
    input  logic               branchTakenFlag,
    input  logic [ADDR_W-1:0]  branchTarget,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr_IFID,
    output logic [ADDR_W-1:0]  pc_IFID,
    output logic               valid_IFID
);

    fetch_state_t       state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx, pc_inc;
    logic [INSTR_W-1:0] hold_buf, hold_buf_nx;
    logic               req_int;
    logic [ADDR_W-1:0]  addr_int;
    logic               ifid_load;
    logic [INSTR_W-1:0] ifid_instr;
    logic               redirect;

    assign redirect = branchTakenFlag;
    assign pc_inc   = pc + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ISSUE;
            pc       <= RESET_PC;
            hold_buf <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            hold_buf <= hold_buf_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        hold_buf_nx = hold_buf;
        req_int     = 1'b0;
        addr_int    = pc;
        ifid_load   = 1'b0;
        ifid_instr  = imem_rdata;

        case (state)
            ISSUE: begin
                if (redirect) begin
                    pc_nx = branchTarget;
                end else begin
                    req_int  = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    if (redirect) begin
                        pc_nx    = branchTarget;
                        state_nx = ISSUE;
                    end else if (stall) begin
                        hold_buf_nx = imem_rdata;
                        state_nx    = HOLD;
                    end else begin
                        // deliver and immediately issue the next sequential fetch
                        ifid_load = 1'b1;
                        pc_nx     = pc_inc;
                        req_int   = 1'b1;
                        addr_int  = pc_inc;
                    end
                end else if (redirect) begin
                    pc_nx    = branchTarget;
                    state_nx = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nx    = branchTarget;
                    state_nx = ISSUE;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    ifid_instr = hold_buf;
                    pc_nx      = pc_inc;
                    req_int    = 1'b1;
                    addr_int   = pc_inc;
                    state_nx   = WAIT;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_nx = branchTarget;
                end
                if (imem_valid) begin
                    state_nx = ISSUE;
                end
            end
            default: state_nx = ISSUE;
        endcase
    end

    // keep the request strobe quiet while reset is held
    assign imem_req  = req_int & rst_n;
    assign imem_addr = addr_int;

    ifid_reg #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_ifid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (branchTakenFlag | flush_ifid),
        .hold      (stall),
        .load      (ifid_load),
        .load_instr(ifid_instr),
        .load_pc   (pc),
        .instr     (instr_IFID),
        .pc        (pc_IFID),
        .valid     (valid_IFID)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush_ifid = 1'b0;
    logic        branchTakenFlag = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [31:0] instr_IFID;
    logic [31:0] pc_IFID;
    logic        valid_IFID;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush_ifid     (flush_ifid),
        .branchTakenFlag(branchTakenFlag),
        .branchTarget   (branchTarget),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .instr_IFID     (instr_IFID),
        .pc_IFID        (pc_IFID),
        .valid_IFID     (valid_IFID)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          s, f, b;
        logic [31:0] t;
        bit          v;
        logic [31:0] d;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit s, bit f, bit b, logic [31:0] t, bit v, logic [31:0] d,
                                bit er, logic [31:0] ea, bit ev, logic [31:0] ep, logic [31:0] ei);
        vec_t r;
        r.s = s; r.f = f; r.b = b; r.t = t; r.v = v; r.d = d;
        r.e_req = er; r.e_addr = ea; r.e_vld = ev; r.e_pc = ep; r.e_instr = ei;
        return r;
    endfunction

    // reference model state (random phase)
    logic [31:0] m_pc, m_buf, m_ipc, m_instr;
    bit          m_out, m_want, m_hasbuf, m_vld;
    bit          mem_busy;
    int          mem_cnt;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //               s f b target        v data          req addr          vld pc            instr
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,        1,32'h0,          0,32'h0,        32'h0));
        vecs.push_back(mk(0,0,0,32'h0,       1,32'h1000,     1,32'h4,          1,32'h0,        32'h1000));
        vecs.push_back(mk(0,0,0,32'h0,       1,32'h1004,     1,32'h8,          1,32'h4,        32'h1004));
        vecs.push_back(mk(1,0,0,32'h0,       1,32'h1008,     0,32'h0,          1,32'h4,        32'h1004));
        vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,        0,32'h0,          1,32'h4,        32'h1004));
        vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,        0,32'h0,          1,32'h4,        32'h1004));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,        1,32'hC,          1,32'h8,        32'h1008));
        vecs.push_back(mk(0,0,0,32'h0,       1,32'h100C,     1,32'h10,         1,32'hC,        32'h100C));
        vecs.push_back(mk(0,0,1,32'h40,      0,32'h0,        0,32'h0,          0,32'h0,        32'h0));
        vecs.push_back(mk(0,0,0,32'h0,       1,32'hBAD0,     0,32'h0,          0,32'h0,        32'h0));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,        1,32'h40,         0,32'h0,        32'h0));
        vecs.push_back(mk(1,0,1,32'h80,      1,32'h2040,     0,32'h0,          0,32'h0,        32'h0));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,        1,32'h80,         0,32'h0,        32'h0));
        vecs.push_back(mk(0,0,0,32'h0,       1,32'h2080,     1,32'h84,         1,32'h80,       32'h2080));
        vecs.push_back(mk(1,0,0,32'h0,       1,32'h2084,     0,32'h0,          1,32'h80,       32'h2080));
        vecs.push_back(mk(1,1,0,32'h0,       0,32'h0,        0,32'h0,          0,32'h0,        32'h0));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,        1,32'h88,         1,32'h84,       32'h2084));
        vecs.push_back(mk(0,0,1,32'hFFFFFFFC,1,32'h2088,     0,32'h0,          0,32'h0,        32'h0));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,        1,32'hFFFFFFFC,   0,32'h0,        32'h0));
        vecs.push_back(mk(0,0,0,32'h0,       1,32'h3000,     1,32'h0,          1,32'hFFFFFFFC, 32'h3000));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,        0,32'h0,          0,32'h0,        32'h0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset req", 32'(imem_req), 32'h0);
        check("reset valid_IFID", 32'(valid_IFID), 32'h0);
        check("reset pc_IFID", pc_IFID, 32'h0);
        check("reset instr_IFID", instr_IFID, 32'h0);
        rst_n = 1'b1;

        // directed table
        foreach (vecs[i]) begin
            stall = vecs[i].s; flush_ifid = vecs[i].f; branchTakenFlag = vecs[i].b;
            branchTarget = vecs[i].t; imem_valid = vecs[i].v; imem_rdata = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d req", i), 32'(imem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) check($sformatf("vec%0d addr", i), imem_addr, vecs[i].e_addr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid_IFID", i), 32'(valid_IFID), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) begin
                check($sformatf("vec%0d pc_IFID", i), pc_IFID, vecs[i].e_pc);
                check($sformatf("vec%0d instr_IFID", i), instr_IFID, vecs[i].e_instr);
            end
        end

        // reset pulse while a request is outstanding; stale response then ignored
        stall = 0; flush_ifid = 0; branchTakenFlag = 0; imem_valid = 0;
        rst_n = 1'b0;
        #1;
        check("midrst req", 32'(imem_req), 32'h0);
        check("midrst addr", imem_addr, 32'h0);
        check("midrst valid_IFID", 32'(valid_IFID), 32'h0);
        check("midrst pc_IFID", pc_IFID, 32'h0);
        check("midrst instr_IFID", instr_IFID, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        imem_valid = 1'b1; imem_rdata = 32'hDEAD_0001;
        #1;
        check("postrst req", 32'(imem_req), 32'h1);
        check("postrst addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        check("postrst stale valid_IFID", 32'(valid_IFID), 32'h0);
        imem_valid = 1'b1; imem_rdata = 32'h4000;
        @(negedge clk);
        check("postrst2 req", 32'(imem_req), 32'h1);
        check("postrst2 addr", imem_addr, 32'h4);
        @(posedge clk);
        #1;
        check("postrst2 valid_IFID", 32'(valid_IFID), 32'h1);
        check("postrst2 pc_IFID", pc_IFID, 32'h0);
        check("postrst2 instr_IFID", instr_IFID, 32'h4000);
        imem_valid = 1'b0;

        // randomized phase against the reference model
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pc = 32'h0; m_out = 0; m_want = 0; m_hasbuf = 0; m_buf = '0;
        m_vld = 0; m_ipc = '0; m_instr = '0;
        mem_busy = 0; mem_cnt = 0;

        for (int c = 0; c < 3000; c++) begin
            bit          e_req, deliver;
            logic [31:0] e_addr, d_word, d_pc, tgt, rnd;
            int          sel;

            imem_valid = mem_busy && (mem_cnt == 0);
            imem_rdata = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            branchTakenFlag = ($urandom_range(0, 9) == 0);
            flush_ifid = branchTakenFlag ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            rnd = $urandom;
            sel = $urandom_range(0, 3);
            case (sel)
                0: tgt = {rnd[31:2], 2'b00};
                1: tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                2: tgt = rnd;
                default: tgt = {24'h0, rnd[7:2], 2'b00};
            endcase
            branchTarget = tgt;

            // what the fetch stage must do this cycle
            e_req = 0; e_addr = '0; deliver = 0; d_word = '0; d_pc = m_pc;
            if (!branchTakenFlag) begin
                if (!m_out && !m_hasbuf) begin
                    e_req = 1; e_addr = m_pc;
                end else if (m_hasbuf && !stall) begin
                    deliver = 1; d_word = m_buf; e_req = 1; e_addr = m_pc + 32'd4;
                end else if (imem_valid && m_out && m_want && !stall) begin
                    deliver = 1; d_word = imem_rdata; e_req = 1; e_addr = m_pc + 32'd4;
                end
            end

            @(negedge clk);
            check($sformatf("rnd%0d req", c), 32'(imem_req), 32'(e_req));
            if (e_req) check($sformatf("rnd%0d addr", c), imem_addr, e_addr);
            check($sformatf("rnd%0d valid_IFID", c), 32'(valid_IFID), 32'(m_vld));
            if (m_vld) begin
                check($sformatf("rnd%0d pc_IFID", c), pc_IFID, m_ipc);
                check($sformatf("rnd%0d instr_IFID", c), instr_IFID, m_instr);
            end

            // advance the model
            if (branchTakenFlag || flush_ifid) m_vld = 0;
            else if (stall) ;
            else if (deliver) begin m_vld = 1; m_ipc = d_pc; m_instr = d_word; end
            else m_vld = 0;

            if (branchTakenFlag) begin
                m_pc = branchTarget;
                m_hasbuf = 0;
                if (imem_valid) m_out = 0;
                else if (m_out) m_want = 0;
            end else begin
                if (imem_valid && m_out) begin
                    if (!m_want) m_out = 0;
                    else if (stall) begin m_hasbuf = 1; m_buf = imem_rdata; m_out = 0; end
                end
                if (e_req) begin m_out = 1; m_want = 1; end
                if (deliver) begin m_pc = m_pc + 32'd4; m_hasbuf = 0; end
            end

            // memory: one outstanding request, response 1..3 cycles later
            if (imem_valid) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (imem_req) begin mem_busy = 1; mem_cnt = $urandom_range(0, 2); end

            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
